// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86-64 core: stall/bubble generation, CC gating and a
// run/drain/stop status FSM. Define PIPE_CTRL_PERF_EN to build the saturating performance counters.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       D_icode_i,
   input  logic [3:0]       d_srcA_i,
   input  logic [3:0]       d_srcB_i,
   input  logic [3:0]       E_icode_i,
   input  logic [3:0]       E_dstM_i,
   input  logic             e_cnd_i,
   input  logic [3:0]       M_icode_i,
   input  logic [2:0]       m_stat_i,
   input  logic [3:0]       W_icode_i,
   input  logic [2:0]       W_stat_i,
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             D_bubble_o,
   output logic             E_bubble_o,
   output logic             M_bubble_o,
   output logic             W_stall_o,
   output logic             set_cc_en_o,
   output logic [2:0]       cpu_stat_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [2:0] SAOK    = 3'd1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_STOP  = 2'd2;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [2:0] cpu_stat_r;
   logic [2:0] cpu_stat_nxt_s;
   logic       load_use_s, ret_pend_s, mispred_s, exc_m_s, exc_w_s;
   logic       f_stall_s, d_stall_s, d_bubble_s, e_bubble_s, m_bubble_s, w_stall_s, set_cc_s;

   assign load_use_s = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE)
                       && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
   assign ret_pend_s = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
   assign mispred_s  = (E_icode_i == IJXX) && !e_cnd_i;
   assign exc_m_s    = (m_stat_i != SAOK);
   assign exc_w_s    = (W_stat_i != SAOK);

   // Per-state control decode; reset forces bubbles into D/E/M and everything else low.
   always_comb begin
      f_stall_s  = 1'b0;
      d_stall_s  = 1'b0;
      d_bubble_s = 1'b0;
      e_bubble_s = 1'b0;
      m_bubble_s = 1'b0;
      w_stall_s  = 1'b0;
      set_cc_s   = 1'b0;
      if (rst_i) begin
         d_bubble_s = 1'b1;
         e_bubble_s = 1'b1;
         m_bubble_s = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               f_stall_s  = load_use_s | ret_pend_s | exc_m_s;
               d_stall_s  = load_use_s;
               d_bubble_s = mispred_s | (ret_pend_s & !load_use_s) | exc_m_s;
               e_bubble_s = mispred_s | load_use_s;
               m_bubble_s = exc_m_s | exc_w_s;
               w_stall_s  = exc_w_s;
               set_cc_s   = (E_icode_i == IOPQ) & !exc_m_s & !exc_w_s;
            end
            ST_DRAIN: begin
               f_stall_s  = 1'b1;
               d_bubble_s = 1'b1;
               e_bubble_s = 1'b1;
               m_bubble_s = 1'b1;
               w_stall_s  = exc_w_s;
            end
            default: begin
               f_stall_s  = 1'b1;
               d_stall_s  = 1'b1;
               e_bubble_s = 1'b1;
               m_bubble_s = 1'b1;
               w_stall_s  = 1'b1;
            end
         endcase
      end
   end

   // Next state; an exception reaching W while M also faults skips the drain phase.
   always_comb begin
      state_nxt_s    = state_r;
      cpu_stat_nxt_s = cpu_stat_r;
      case (state_r)
         ST_RUN: begin
            if (exc_m_s && exc_w_s) begin
               state_nxt_s    = ST_STOP;
               cpu_stat_nxt_s = W_stat_i;
            end else if (exc_m_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (exc_w_s) begin
               state_nxt_s    = ST_STOP;
               cpu_stat_nxt_s = W_stat_i;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_STOP: begin
            state_nxt_s = ST_STOP;
         end
         default: begin
            state_nxt_s = ST_STOP;
         end
      endcase
   end

   // FSM and latched status registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= ST_RUN;
         cpu_stat_r <= SAOK;
      end else begin
         state_r    <= state_nxt_s;
         cpu_stat_r <= cpu_stat_nxt_s;
      end
   end

   assign F_stall_o   = f_stall_s;
   assign D_stall_o   = d_stall_s;
   assign D_bubble_o  = d_bubble_s;
   assign E_bubble_o  = e_bubble_s;
   assign M_bubble_o  = m_bubble_s;
   assign W_stall_o   = w_stall_s;
   assign set_cc_en_o = set_cc_s;
   assign cpu_stat_o  = cpu_stat_r;
   assign halted_o    = (state_r == ST_STOP);

`ifdef PIPE_CTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cycle_cnt_r, stall_cnt_r, flush_cnt_r, retire_cnt_r;
   logic             live_s, retire_s;

   assign live_s   = (state_r != ST_STOP);
   assign retire_s = (W_stat_i == SAOK) && (W_icode_i != INOP) && !w_stall_s;

   // Saturating event counters, frozen once the core has stopped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_cnt_r  <= {CNT_W{1'b0}};
         stall_cnt_r  <= {CNT_W{1'b0}};
         flush_cnt_r  <= {CNT_W{1'b0}};
         retire_cnt_r <= {CNT_W{1'b0}};
      end else if (live_s) begin
         if (cycle_cnt_r != CNT_MAX) cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
         else                        cycle_cnt_r <= cycle_cnt_r;
         if ((state_r == ST_RUN) && f_stall_s && (stall_cnt_r != CNT_MAX))
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         else
            stall_cnt_r <= stall_cnt_r;
         if (mispred_s && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
         else                                       flush_cnt_r <= flush_cnt_r;
         if (retire_s && (retire_cnt_r != CNT_MAX)) retire_cnt_r <= retire_cnt_r + CNT_ONE;
         else                                       retire_cnt_r <= retire_cnt_r;
      end else begin
         cycle_cnt_r  <= cycle_cnt_r;
         stall_cnt_r  <= stall_cnt_r;
         flush_cnt_r  <= flush_cnt_r;
         retire_cnt_r <= retire_cnt_r;
      end
   end

   assign cycle_cnt_o  = cycle_cnt_r;
   assign stall_cnt_o  = stall_cnt_r;
   assign flush_cnt_o  = flush_cnt_r;
   assign retire_cnt_o = retire_cnt_r;
`else
   assign cycle_cnt_o  = {CNT_W{1'b0}};
   assign stall_cnt_o  = {CNT_W{1'b0}};
   assign flush_cnt_o  = {CNT_W{1'b0}};
   assign retire_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized plus directed bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

   localparam int CNT_W = 4;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_i;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
   logic e_cnd;
   logic [2:0] m_stat, W_stat;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted;
   logic [2:0] cpu_stat;
   logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0=running, 1=draining, 2=stopped
   int m_mode;
   int m_stat_lat;
   int c_cycle, c_stall, c_flush, c_retire;
   bit e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc, e_mp;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
      .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_cnd_i(e_cnd),
      .M_icode_i(M_icode), .m_stat_i(m_stat), .W_icode_i(W_icode), .W_stat_i(W_stat),
      .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble), .E_bubble_o(E_bubble),
      .M_bubble_o(M_bubble), .W_stall_o(W_stall), .set_cc_en_o(set_cc_en),
      .cpu_stat_o(cpu_stat), .halted_o(halted),
      .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt), .retire_cnt_o(retire_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= (1 << CNT_W) - 1) ? v : v + 1;
   endfunction

   task automatic idle_inputs();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
      m_stat = 3'd1; W_stat = 3'd1;
   endtask

   task automatic calc_exp();
      bit lu, rp, em, ew;
      lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF
           && (E_dstM == d_srcA || E_dstM == d_srcB);
      rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
      e_mp = (E_icode == 4'h7) && !e_cnd;
      em = (m_stat != 3'd1);
      ew = (W_stat != 3'd1);
      if (m_mode == 0) begin
         e_fs = lu || rp || em;
         e_ds = lu;
         e_db = e_mp || (rp && !lu) || em;
         e_eb = e_mp || lu;
         e_mb = em || ew;
         e_ws = ew;
         e_cc = (E_icode == 4'h6) && !em && !ew;
      end else if (m_mode == 1) begin
         e_fs = 1; e_ds = 0; e_db = 1; e_eb = 1; e_mb = 1; e_ws = ew; e_cc = 0;
      end else begin
         e_fs = 1; e_ds = 1; e_db = 0; e_eb = 1; e_mb = 1; e_ws = 1; e_cc = 0;
      end
   endtask

   task automatic check_all();
      check_eq("F_stall",  F_stall,  e_fs);
      check_eq("D_stall",  D_stall,  e_ds);
      check_eq("D_bubble", D_bubble, e_db);
      check_eq("E_bubble", E_bubble, e_eb);
      check_eq("M_bubble", M_bubble, e_mb);
      check_eq("W_stall",  W_stall,  e_ws);
      check_eq("set_cc",   set_cc_en, e_cc);
      check_eq("cpu_stat", cpu_stat, (m_mode == 2) ? m_stat_lat : 1);
      check_eq("halted",   halted,   m_mode == 2);
      check_eq("cycle_cnt",  cycle_cnt,  c_cycle);
      check_eq("stall_cnt",  stall_cnt,  c_stall);
      check_eq("flush_cnt",  flush_cnt,  c_flush);
      check_eq("retire_cnt", retire_cnt, c_retire);
   endtask

   // one clock: check mid-cycle, then advance the model across the edge
   task automatic run_cycle();
      @(negedge clk);
      calc_exp();
      check_all();
      if (PERF && m_mode != 2) begin
         c_cycle = sat_inc(c_cycle);
         if (m_mode == 0 && e_fs) c_stall = sat_inc(c_stall);
         if (e_mp) c_flush = sat_inc(c_flush);
         if (W_stat == 3'd1 && W_icode != 4'h1 && !e_ws) c_retire = sat_inc(c_retire);
      end
      if (m_mode == 0 && m_stat != 3'd1 && W_stat != 3'd1) begin
         m_mode = 2; m_stat_lat = W_stat;
      end else if (m_mode == 0 && m_stat != 3'd1) begin
         m_mode = 1;
      end else if (m_mode == 1 && W_stat != 3'd1) begin
         m_mode = 2; m_stat_lat = W_stat;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      #2 rst_i = 1'b1;
      #1;
      m_mode = 0; m_stat_lat = 1;
      c_cycle = 0; c_stall = 0; c_flush = 0; c_retire = 0;
      check_eq("rst_D_bubble", D_bubble, 1);
      check_eq("rst_E_bubble", E_bubble, 1);
      check_eq("rst_M_bubble", M_bubble, 1);
      check_eq("rst_F_stall", F_stall, 0);
      check_eq("rst_D_stall", D_stall, 0);
      check_eq("rst_W_stall", W_stall, 0);
      check_eq("rst_set_cc", set_cc_en, 0);
      check_eq("rst_halted", halted, 0);
      check_eq("rst_cpu_stat", cpu_stat, 1);
      check_eq("rst_cycle_cnt", cycle_cnt, 0);
      @(posedge clk);
      #1 rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      idle_inputs();
      #1;
      apply_reset();

      // load-use: mrmovq ->%rax in E, addq %rax,%rbx in D, then the bubble reaches E
      D_icode = 4'h6; d_srcA = 4'h0; d_srcB = 4'h3; E_icode = 4'h5; E_dstM = 4'h0;
      run_cycle();
      E_icode = 4'h1; E_dstM = 4'hF;
      run_cycle();

      // not-taken jne in E
      idle_inputs(); E_icode = 4'h7; e_cnd = 1'b0;
      run_cycle();
      idle_inputs();
      run_cycle();

      // ret walking D -> E -> M -> W
      D_icode = 4'h9; run_cycle();
      D_icode = 4'h1; E_icode = 4'h9; run_cycle();
      E_icode = 4'h1; M_icode = 4'h9; run_cycle();
      M_icode = 4'h1; W_icode = 4'h9; run_cycle();

      // simultaneous load-use + ret, and mispredict + ret
      idle_inputs(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
      run_cycle();
      idle_inputs(); D_icode = 4'h9; E_icode = 4'h7; e_cnd = 1'b0;
      run_cycle();

      // address fault on an addq stream: drain, then stop
      idle_inputs(); E_icode = 4'h6; m_stat = 3'd3; W_icode = 4'h6;
      run_cycle();
      m_stat = 3'd1; W_stat = 3'd3;
      run_cycle();
      idle_inputs(); E_icode = 4'h6;
      for (int i = 0; i < 3; i++) run_cycle();
      apply_reset();

      // reset while draining
      idle_inputs(); m_stat = 3'd3;
      run_cycle();
      idle_inputs();
      run_cycle();
      apply_reset();
      run_cycle();

      // simultaneous M and W faults go straight to stop
      idle_inputs(); m_stat = 3'd4; W_stat = 3'd2;
      run_cycle();
      idle_inputs();
      run_cycle();
      apply_reset();

      // long idle run for counter saturation
      W_icode = 4'h6;
      for (int i = 0; i < 20; i++) run_cycle();

      // randomized episodes
      for (int ep = 0; ep < 40; ep++) begin
         apply_reset();
         for (int c = 0; c < 24; c++) begin
            D_icode = 4'($urandom_range(0, 11));
            E_icode = 4'($urandom_range(0, 11));
            M_icode = 4'($urandom_range(0, 11));
            W_icode = 4'($urandom_range(0, 11));
            d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            E_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            e_cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            W_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            run_cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
